// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA framebuffer path.
//   H_DISPLAY / V_DISPLAY : visible area of the 640x480 mode
//   FB_PIXELS             : pixels per frame
//   pixel_t               : one RGB332 framebuffer word
//   state_t               : arbiter state (S_WAIT until the first vblank, then S_RUN)
package vga_pkg;

  localparam int unsigned H_DISPLAY = 640;
  localparam int unsigned V_DISPLAY = 480;
  localparam int unsigned FB_PIXELS = H_DISPLAY * V_DISPLAY;
  localparam int unsigned PIX_W     = 8;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic {
    S_WAIT,
    S_RUN
  } state_t;

endpackage

// File: rtl/vga_pix_fifo.sv
// Small synchronous FIFO holding prefetched display pixels.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush          : empty the FIFO this cycle (wins over push and pop)
//   push, wdata    : write one entry (ignored when full)
//   pop, rdata     : rdata shows the head; pop removes it (ignored when empty)
//   count          : entries currently held
//   empty, full    : status flags
module vga_pix_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer access controller between the VGA sync generator and a single-port
// synchronous RAM. Display pixels are prefetched into a small FIFO so a pixel is ready on
// every pix_en tick; every RAM cycle the prefetch does not need goes to the host port.
// Optional build macro: VGA_FB_HOST_READ_EN enables host reads (otherwise reads are
// acknowledged but perform no RAM access, and host_rvalid/host_rdata are tied to 0).
// Ports:
//   clk, rst_n                 : clock (4x pixel rate), asynchronous active-low reset
//   pix_en, x, y, displaying   : timing from the sync generator
//   pix_data, underflow        : registered pixel to the DAC, sticky FIFO-empty flag
//   host_valid/we/addr/wdata   : host request; host_ready accepts it this cycle
//   host_rvalid, host_rdata    : read return, one cycle after an accepted read
//   ram_en/we/addr/wdata/rdata : RAM port, read data has 1-cycle latency
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FB_PIXELS  = vga_pkg::FB_PIXELS,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              displaying,
  output logic [DATA_W-1:0] pix_data,
  output logic              underflow,
  input  logic              host_valid,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned        CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [9:0]         VBLANK_Y  = 10'(V_DISPLAY);
  localparam logic [ADDR_W-1:0]  FETCH_END = ADDR_W'(FB_PIXELS);
  localparam logic [CW-1:0]      FIFO_CAP  = CW'(FIFO_DEPTH);

  state_t              state_q;
  logic                in_vblank_q;
  logic                inflight_q;
  logic [ADDR_W-1:0]   fetch_addr_q;
  logic [DATA_W-1:0]   pix_data_q;
  logic                underflow_q;

  logic                in_vblank, flush, display_issue, host_access;
  logic [CW-1:0]       fifo_count;
  logic                fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic [DATA_W-1:0]   fifo_rdata;

  // Only y drives the frame logic; the column counter is not needed.
  logic unused_x;
  assign unused_x = ^x;

  assign in_vblank = (y >= VBLANK_Y);
  assign flush     = in_vblank && !in_vblank_q;

  // No fetch in the flush cycle: fetch_addr_q is being rewound to 0.
  assign display_issue = (state_q == S_RUN) && !flush && (fetch_addr_q < FETCH_END) &&
                         ((fifo_count + CW'(inflight_q)) < FIFO_CAP);

  // Data returning during a flush belongs to the old frame; the FIFO flush drops it.
  assign fifo_push = inflight_q && !flush;
  assign fifo_pop  = pix_en && displaying && !flush;

  assign host_ready = host_valid && !display_issue;
`ifdef VGA_FB_HOST_READ_EN
  assign host_access = host_ready;
`else
  assign host_access = host_ready && host_we;
`endif

  assign ram_en    = display_issue || host_access;
  assign ram_we    = host_ready && host_we;
  assign ram_addr  = display_issue ? fetch_addr_q : host_addr;
  assign ram_wdata = host_wdata;

  assign pix_data  = pix_data_q;
  assign underflow = underflow_q;

  vga_pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (fifo_push),
    .wdata (ram_rdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  logic unused_full;
  assign unused_full = fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_WAIT;
      // Treat reset as inside vblank so only a real y crossing counts as an edge.
      in_vblank_q  <= 1'b1;
      inflight_q   <= 1'b0;
      fetch_addr_q <= '0;
      pix_data_q   <= '0;
      underflow_q  <= 1'b0;
    end else begin
      in_vblank_q <= in_vblank;
      inflight_q  <= display_issue;
      if (flush) begin
        state_q      <= S_RUN;
        fetch_addr_q <= '0;
      end else if (display_issue) begin
        fetch_addr_q <= fetch_addr_q + ADDR_W'(1);
      end
      if (pix_en) begin
        if (!displaying) begin
          pix_data_q <= '0;
        end else if (flush || fifo_empty) begin
          pix_data_q  <= '0;
          underflow_q <= 1'b1;
        end else begin
          pix_data_q <= fifo_rdata;
        end
      end
    end
  end

`ifdef VGA_FB_HOST_READ_EN
  logic rvalid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rvalid_q <= 1'b0;
    else        rvalid_q <= host_ready && !host_we;
  end

  // RAM output is valid exactly in the cycle after the accepted read.
  assign host_rvalid = rvalid_q;
  assign host_rdata  = rvalid_q ? ram_rdata : '0;
`else
  assign host_rvalid = 1'b0;
  assign host_rdata  = '0;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter. Uses a shortened frame (FB_PIXELS = two lines)
// so the frame-end and re-flush behaviour fit in a short run. Honours VGA_FB_HOST_READ_EN.
module tb_vga_fb_arbiter;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned FBP    = 1280;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned LINE_W = 640;
  localparam int unsigned HBLANK = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pix_en = 1'b0;
  logic [9:0]        x = '0;
  logic [9:0]        y = 10'd479;
  logic              displaying = 1'b0;
  logic [DATA_W-1:0] pix_data;
  logic              underflow;
  logic              host_valid = 1'b0;
  logic              host_we = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic              host_ready, host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem    [0:(1<<ADDR_W)-1];
  logic [7:0] img    [0:FBP-1];
  logic [7:0] shadow [int];

  logic              c_ram_en, c_ram_we, c_host_ready;
  logic [ADDR_W-1:0] c_ram_addr;
  int                en_cnt;
  int                k;
  int                acc_min;

  vga_fb_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FB_PIXELS  (FBP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .x           (x),
    .y           (y),
    .displaying  (displaying),
    .pix_data    (pix_data),
    .underflow   (underflow),
    .host_valid  (host_valid),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ready  (host_ready),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM, read-before-write.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: capture combinational outputs mid-cycle, return #1 after the edge.
  task automatic step();
    @(negedge clk);
    c_ram_en     = ram_en;
    c_ram_we     = ram_we;
    c_ram_addr   = ram_addr;
    c_host_ready = host_ready;
    if (ram_en) en_cnt++;
    @(posedge clk);
    #1;
  endtask

  // One pixel period (4 clks, pix_en on the first). hmode: 0 idle, 1 writes every clk,
  // 2 random writes. Writes land above the displayed image.
  task automatic pixel(input bit disp, input int hmode);
    int acc = 0;
    logic [7:0] exp_pix;
    for (int c = 0; c < 4; c++) begin
      pix_en     = (c == 0);
      displaying = disp;
      host_valid = (hmode == 1) || ((hmode == 2) && ($urandom_range(0, 1) == 1));
      host_we    = 1'b1;
      host_addr  = ADDR_W'(FBP + $urandom_range(0, 4095));
      host_wdata = 8'($urandom);
      step();
      if (c_host_ready) begin
        acc++;
        shadow[int'(host_addr)] = host_wdata;
      end
      if (c == 0) begin
        exp_pix = disp ? img[k] : 8'h00;
        if (disp) k++;
        check("pix_data", 32'(pix_data), 32'(exp_pix));
      end
    end
    pix_en     = 1'b0;
    host_valid = 1'b0;
    if (hmode == 1 && acc < acc_min) acc_min = acc;
  endtask

  task automatic line(input int hmode);
    for (int i = 0; i < int'(LINE_W); i++) begin
      x = 10'(i);
      pixel(1'b1, hmode);
    end
    for (int i = 0; i < int'(HBLANK); i++) pixel(1'b0, hmode);
    check("underflow_line", 32'(underflow), 0);
  endtask

  initial begin
    for (int i = 0; i < int'(FBP); i++) begin
      img[i] = 8'($urandom);
    end
    img[1] = img[0] ^ 8'hFF;  // a replayed stale word would show up as a duplicate
    for (int i = 0; i < int'(FBP); i++) mem[i] = img[i];

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_pix_data", 32'(pix_data), 0);
    check("rst_underflow", 32'(underflow), 0);
    check("rst_rvalid", 32'(host_rvalid), 0);
    check("rst_rdata", 32'(host_rdata), 0);
    check("rst_ram_en", 32'(ram_en), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    rst_n = 1'b1;

    // No fetching before the first vblank edge
    en_cnt = 0;
    repeat (6) step();
    check("wait_no_fetch", en_cnt, 0);

    // First vblank edge; host request in the same cycle proceeds
    y          = 10'd480;
    host_valid = 1'b1;
    host_we    = 1'b1;
    host_addr  = ADDR_W'(FBP + 100);
    host_wdata = 8'($urandom);
    step();
    check("edge_host_ready", 32'(c_host_ready), 1);
    shadow[int'(host_addr)] = host_wdata;
    host_wdata = 8'($urandom);
    for (int i = 0; i < int'(DEPTH); i++) begin
      step();
      check("prefill_en", 32'(c_ram_en), 1);
      check("prefill_we", 32'(c_ram_we), 0);
      check("prefill_addr", 32'(c_ram_addr), i);
      check("prefill_host_ready", 32'(c_host_ready), 0);
    end
    step();
    check("post_prefill_ready", 32'(c_host_ready), 1);
    check("post_prefill_addr", 32'(c_ram_addr), 32'(host_addr));
    shadow[int'(host_addr)] = host_wdata;
    host_valid = 1'b0;
    step();
    check("fifo_full_idle", 32'(c_ram_en), 0);

    // Frame 0: line 0 quiet, line 1 with host writes every clk
    k = 0;
    for (int i = 0; i < 3; i++) pixel(1'b0, 0);
    y = 10'd0;
    line(0);
    y = 10'd1;
    acc_min = 4;
    line(1);
    check("host_share_ge3", 32'(acc_min >= 3), 1);

    // End of frame: no fetch beyond FB_PIXELS
    y = 10'd2;
    en_cnt = 0;
    for (int i = 0; i < 8; i++) pixel(1'b0, 0);
    check("frame_end_no_fetch", en_cnt, 0);
    foreach (shadow[a]) check("ram_contents", 32'(mem[a]), 32'(shadow[a]));

    // Host write then read of 0x1234
    host_valid = 1'b1;
    host_we    = 1'b1;
    host_addr  = ADDR_W'(32'h1234);
    host_wdata = 8'hA5;
    step();
    check("hw_ready", 32'(c_host_ready), 1);
    check("hw_we", 32'(c_ram_we), 1);
    host_we = 1'b0;
    step();
    host_valid = 1'b0;
    check("hr_ready", 32'(c_host_ready), 1);
`ifdef VGA_FB_HOST_READ_EN
    check("hr_ram_en", 32'(c_ram_en), 1);
    check("hr_rvalid", 32'(host_rvalid), 1);
    check("hr_rdata", 32'(host_rdata), 32'h A5);
`else
    check("hr_ram_en", 32'(c_ram_en), 0);
    check("hr_rvalid", 32'(host_rvalid), 0);
    check("hr_rdata", 32'(host_rdata), 0);
`endif
    step();
    check("hr_rvalid_pulse", 32'(host_rvalid), 0);
    check("hw_mem", 32'(mem[32'h1234]), 32'hA5);

    // Flush while a display read is in flight
    y = 10'd479;
    step();
    y = 10'd480;
    step();
    y = 10'd479;
    step();
    check("inflight_issue_addr", 32'(c_ram_addr), 0);
    check("inflight_issue_en", 32'(c_ram_en), 1);
    y          = 10'd480;
    host_valid = 1'b1;
    host_we    = 1'b1;
    host_addr  = ADDR_W'(FBP + 200);
    host_wdata = 8'($urandom);
    step();
    check("flush_host_ready", 32'(c_host_ready), 1);
    check("flush_host_we", 32'(c_ram_we), 1);
    check("flush_host_addr", 32'(c_ram_addr), 32'(host_addr));
    host_valid = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      step();
      check("refetch_addr", 32'(c_ram_addr), i);
      check("refetch_en", 32'(c_ram_en), 1);
    end
    step();
    check("refetch_stop", 32'(c_ram_en), 0);
    k = 0;
    for (int i = 0; i < 2; i++) pixel(1'b0, 0);
    y = 10'd0;
    line(2);

    // Forced underflow: pop on every clk right after a flush
    y = 10'd479;
    step();
    y = 10'd480;
    step();
    check("pre_underflow", 32'(underflow), 0);
    pix_en     = 1'b1;
    displaying = 1'b1;
    step();
    check("uf_pix_data", 32'(pix_data), 0);
    check("uf_flag", 32'(underflow), 1);
    repeat (8) step();
    pix_en     = 1'b0;
    displaying = 1'b0;
    y          = 10'd100;
    repeat (8) step();
    check("uf_sticky", 32'(underflow), 1);

    // Mid-frame reset
    rst_n = 1'b0;
    #1;
    check("mrst_underflow", 32'(underflow), 0);
    check("mrst_pix_data", 32'(pix_data), 0);
    check("mrst_ram_en", 32'(ram_en), 0);
    step();
    rst_n  = 1'b1;
    en_cnt = 0;
    repeat (10) step();
    check("mrst_no_fetch", en_cnt, 0);
    y = 10'd479;
    step();
    y = 10'd480;
    step();
    step();
    check("mrst_resume_en", 32'(c_ram_en), 1);
    check("mrst_resume_addr", 32'(c_ram_addr), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Framebuffer access controller between the 640x480 VGA sync generator and a single-port synchronous framebuffer RAM. It prefetches display pixels into a small FIFO, so one pixel is available on every pixel-enable tick, and gives the remaining RAM slots to a host write/read port through a valid/ready handshake. The display side always has priority. The host receives every cycle the prefetch does not need.

## Interface
- `ADDR_W`, 19: framebuffer word address width.
- `DATA_W`, 8: pixel width (RGB332).
- `FB_PIXELS`, 307200: pixels per frame (640*480).
- `FIFO_DEPTH`, 4: prefetch FIFO entries (power of two, ≥2).
- `clk` in 1: system clock, 4x pixel rate.
- `rst_n` in 1: asynchronous reset, active low.
- `pix_en` in 1: pixel tick, one clk in four.
- `x` in 10: horizontal counter from the sync block.
- `y` in 10: vertical counter from the sync block.
- `displaying` in 1: active-area flag from the sync block.
- `pix_data` out DATA_W: registered pixel to the DAC.
- `underflow` out 1: sticky flag, FIFO was empty when a pixel was needed.
- `host_valid` in 1: host request.
- `host_we` in 1: 1 = write, 0 = read.
- `host_addr` in ADDR_W: host address.
- `host_wdata` in DATA_W: host write data.
- `host_ready` out 1: request accepted this cycle.
- `host_rvalid` out 1: read data valid.
- `host_rdata` out DATA_W: read data.
- `ram_en`, `ram_we` out 1: RAM strobe and write enable.
- `ram_addr` out ADDR_W: RAM address.
- `ram_wdata` out DATA_W: RAM write data.
- `ram_rdata` in DATA_W: RAM read data, 1-cycle latency.

## Operation
- **States.**
  - `S_WAIT`: entered from reset; no fetches.
  - `S_RUN`: entered on the first vblank rising edge.
  - The vblank edge is `y >= 480` now and `y < 480` in the previous cycle.
- **Frame flush.** Every vblank rising edge does the following in one cycle:
  - `fetch_addr` ← 0.
  - The FIFO is emptied.
  - Any in-flight display read is tagged stale; its data is dropped on return.
- **Prefetch.**
  - In `S_RUN`, issue a display read when `occupancy + inflight < FIFO_DEPTH` and `fetch_addr < FB_PIXELS`.
  - Each issued read increments `fetch_addr` by 1.
  - At `FB_PIXELS`, fetching stops until the next flush.
  - Returned data is pushed into the FIFO.
- **Pop.** When `pix_en && displaying`, pop the FIFO head into `pix_data`.
  - If the FIFO is empty: `pix_data` ← 0 and `underflow` ← 1.
- **Blanking.** When `pix_en && !displaying`, `pix_data` ← 0.
- **Arbitration.**
  - `host_ready = host_valid && !display_issue`, evaluated combinationally each cycle.
  - An accepted host request drives `ram_en` together with `host_we`, `host_addr` and `host_wdata`.
  - Steady state: display uses at most 1 slot in 4, so the host gets ≥3 of every 4 cycles.
- **Host read.** `host_rvalid` pulses one cycle after an accepted read, with `host_rdata` = `ram_rdata`.
- **Simultaneous events.**
  - Flush and a pop in the same cycle: the flush wins and the pop sees an empty FIFO. This cannot occur in legal timing.
  - Flush and an accepted host request in the same cycle: the host request proceeds unaffected.

## Timing
- `pix_data` updates on the clk edge where `pix_en` is high. It therefore lags `x`/`y` by one clk, which matches the sync block's registered `hsync`/`vsync`.
- Display read: issue at cycle N, RAM data at N+1, pushed into the FIFO at the N+1 edge, poppable at N+2.
- Host write: accepted at cycle N, written in RAM at the N edge.
- Host read: accepted at cycle N, `host_rvalid` high during N+1.
- Reset values:
  - State `S_WAIT`.
  - `pix_data`, `underflow`, `host_rvalid` and `host_rdata` are 0.
  - FIFO empty, `fetch_addr` 0.
  - `ram_en` and `ram_we` are 0, since they are combinational from the reset state.
- Reset mid-frame: all state clears immediately. Display resumes after the next vblank edge.
- `underflow` clears only on reset.

## Configuration
- `VGA_FB_HOST_READ_EN` defined:
  - Host reads are supported as described under Operation.
- `VGA_FB_HOST_READ_EN` undefined:
  - Requests with `host_we=0` still get `host_ready` but perform no RAM access.
  - `host_rvalid` and `host_rdata` are tied to 0.
  - The read-return register is absent.

## Structure
- Package `vga_pkg` holds:
  - `H_DISPLAY` = 640, `V_DISPLAY` = 480, `FB_PIXELS`.
  - Typedef `pixel_t` (DATA_W bits).
  - The state enum `S_WAIT`/`S_RUN`.
- Sub-module `vga_pix_fifo`:
  - Synchronous FIFO with push, pop, flush, `count`, `empty` and `full`.
  - FIFO_DEPTH entries, asynchronous active-low reset.

## Test plan
- **Reset then prefill.** Release `rst_n`, drive y from 479 to 480. Expect display reads to addresses 0–3 in four consecutive cycles, FIFO count 4, `host_ready` 0 during those cycles.
- **Active line.** Preload RAM[i] = i[7:0], run one line. Expect `pix_data` to be 0x00, 0x01, … on successive `pix_en`, `underflow` staying 0, address 640 at the start of line 1.
- **Host contention.** Hold `host_valid=1` with writes during an active line. Expect ≥3 host accepts per 4 clks, no underflow, and RAM contents updated.
- **Host read** (macro defined). Write 0xA5 to 0x1234, then read it back. Expect `host_rvalid` one cycle after accept with `host_rdata` = 0xA5.
- **Forced underflow.** Force the FIFO empty by holding `pix_en` high on every clk. Expect `pix_data` = 0 on the empty pop and `underflow` = 1, held until reset.
- **End of frame and flush.** Run past pixel 307199: no fetches beyond `FB_PIXELS`. At the next vblank edge, fetching restarts at address 0. A read in flight at the flush is dropped, and the first popped pixel of the new frame equals RAM[0].
